// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-ported word RAM between instruction
// fetch and load/store. One request in flight: IDLE -> ACCESS (1 cycle) -> RESP.
module mem_arbiter #(
    parameter int DEPTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid_i,
    output logic        if_req_ready_o,
    input  logic [31:0] if_addr_i,
    output logic        if_rsp_valid_o,
    input  logic        if_rsp_ready_i,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    input  logic        d_req_valid_i,
    output logic        d_req_ready_o,
    input  logic [31:0] d_addr_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_wstrb_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_rsp_valid_o,
    input  logic        d_rsp_ready_i,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_wstrb_o,
    output logic        ram_re_o,
    input  logic [31:0] ram_data_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    state_t      state, state_next;
    owner_t      owner, last_grant;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic        we_q, err_q;
    logic        grant_if, grant_d, in_range, rsp_done;

    assign in_range = (addr_q[31:DEPTH+2] == '0);

    always_comb begin
        state_next  = state;
        grant_if    = 1'b0;
        grant_d     = 1'b0;
        rsp_done    = 1'b0;
        ram_addr_o  = '0;
        ram_data_o  = '0;
        ram_wstrb_o = '0;
        ram_we_o    = 1'b0;
        ram_re_o    = 1'b0;
        case (state)
            IDLE: begin
                // Fetch wins a tie only when data was granted last.
                if (!rst) begin
                    grant_if = if_req_valid_i && (!d_req_valid_i || last_grant == OWN_D);
                    grant_d  = d_req_valid_i && !grant_if;
                end
                if (grant_if || grant_d) state_next = ACCESS;
            end
            ACCESS: begin
                ram_addr_o  = addr_q;
                ram_data_o  = wdata_q;
                ram_wstrb_o = wstrb_q;
                ram_we_o    = we_q && in_range && !rst;
                ram_re_o    = !we_q && in_range;
                state_next  = RESP;
            end
            RESP: begin
                rsp_done = (owner == OWN_IF) ? if_rsp_ready_i : d_rsp_ready_i;
                if (rsp_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_D;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_if) begin
                owner      <= OWN_IF;
                last_grant <= OWN_IF;
                addr_q     <= if_addr_i;
                we_q       <= 1'b0;
                wstrb_q    <= '0;
                wdata_q    <= '0;
            end else if (grant_d) begin
                owner      <= OWN_D;
                last_grant <= OWN_D;
                addr_q     <= d_addr_i;
                we_q       <= d_we_i;
                wstrb_q    <= d_wstrb_i;
                wdata_q    <= d_wdata_i;
            end
            if (state == ACCESS) begin
                rdata_q <= (!we_q && in_range) ? ram_data_i : '0;
                err_q   <= !in_range;
            end
        end
    end

    assign if_req_ready_o = grant_if;
    assign d_req_ready_o  = grant_d;
    assign if_rsp_valid_o = (state == RESP) && (owner == OWN_IF);
    assign d_rsp_valid_o  = (state == RESP) && (owner == OWN_D);
    assign if_rdata_o     = (owner == OWN_IF) ? rdata_q : '0;
    assign d_rdata_o      = (owner == OWN_D) ? rdata_q : '0;
    assign if_err_o       = (owner == OWN_IF) && err_q;
    assign d_err_o        = (owner == OWN_D) && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model (pending request + age since grant)
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;
    localparam int DEPTH = 10;
    localparam int WORDS = 1 << DEPTH;

    logic        clk = 1'b0, rst = 1'b1;
    logic        if_v = 1'b0, if_rr = 1'b1;
    logic [31:0] if_a = '0;
    logic        d_v = 1'b0, d_we = 1'b0, d_rr = 1'b1;
    logic [3:0]  d_st = '0;
    logic [31:0] d_a = '0, d_wd = '0;
    logic        if_req_ready_o, if_rsp_valid_o, if_err_o;
    logic        d_req_ready_o, d_rsp_valid_o, d_err_o;
    logic [31:0] if_rdata_o, d_rdata_o, ram_addr_o, ram_data_o, ram_data_i;
    logic        ram_we_o, ram_re_o;
    logic [3:0]  ram_wstrb_o;

    mem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid_i(if_v), .if_req_ready_o(if_req_ready_o), .if_addr_i(if_a),
        .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_ready_i(if_rr),
        .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .d_req_valid_i(d_v), .d_req_ready_o(d_req_ready_o), .d_addr_i(d_a),
        .d_we_i(d_we), .d_wstrb_i(d_st), .d_wdata_i(d_wd),
        .d_rsp_valid_o(d_rsp_valid_o), .d_rsp_ready_i(d_rr),
        .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_we_o(ram_we_o),
        .ram_wstrb_o(ram_wstrb_o), .ram_re_o(ram_re_o), .ram_data_i(ram_data_i)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [WORDS];
    assign ram_data_i = ram[ram_addr_o[DEPTH+1:2]];

    int errors = 0, checks = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic fail_now(input string n);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake", n);
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 4)  return 32'hDEADBEEF;
        if (i == 8)  return 32'h11223344;
        if (i == 12) return 32'hCAFEF00D;
        return 32'(i) * 32'h9E3779B9 + 32'h01234567;
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return (a >> (DEPTH + 2)) == 0;
    endfunction

    // Reference model: memory image, one pending transaction, age 1 = RAM cycle, 2 = response
    logic [31:0] mm [WORDS];
    bit          mem_ready = 1'b0;
    bit          m_pend = 1'b0, m_own = 1'b0, m_last = 1'b1, m_we = 1'b0, m_err = 1'b0;
    int          m_age = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_wstrb = '0;
    bit          glog[$];
    int          we_cnt = 0, re_cnt = 0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < WORDS; i++) begin
                ram[i] <= init_word(i);
                mm[i] = init_word(i);
            end
            mem_ready <= 1'b1;
        end else begin
            if (ram_we_o) begin
                we_cnt++;
                for (int b = 0; b < 4; b++)
                    if (ram_wstrb_o[b]) ram[ram_addr_o[DEPTH+1:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
            end
            if (ram_re_o) re_cnt++;
            if (!rst && if_req_ready_o && if_v) glog.push_back(1'b0);
            if (!rst && d_req_ready_o && d_v) glog.push_back(1'b1);
            if (rst) begin
                m_pend = 1'b0;
                m_last = 1'b1;
            end else if (!m_pend) begin
                if (if_v && (!d_v || m_last)) begin
                    m_pend = 1'b1; m_own = 1'b0; m_addr = if_a;
                    m_we = 1'b0; m_wstrb = '0; m_wdata = '0;
                end else if (d_v) begin
                    m_pend = 1'b1; m_own = 1'b1; m_addr = d_a;
                    m_we = d_we; m_wstrb = d_st; m_wdata = d_wd;
                end
                if (m_pend) begin
                    m_age  = 1;
                    m_last = m_own;
                end
            end else if (m_age == 1) begin
                m_err   = !in_rng(m_addr);
                m_rdata = (!m_we && !m_err) ? mm[m_addr[DEPTH+1:2]] : '0;
                if (m_we && !m_err)
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) mm[m_addr[DEPTH+1:2]][8*b +: 8] = m_wdata[8*b +: 8];
                m_age = 2;
            end else if (m_own ? d_rr : if_rr) begin
                m_pend = 1'b0;
            end
        end
    end

    logic [31:0] if_last_rdata = '0, d_last_rdata = '0;
    logic        if_last_err = 1'b0, d_last_err = 1'b0;
    int          d_seen = 0;

    always @(negedge clk) begin : cmp
        logic acc, inr, e_ifr, e_dr, e_ifv, e_dv;
        if (mem_ready) begin
            if (d_rsp_valid_o) d_seen++;
            if (if_rsp_valid_o && if_rr) begin if_last_rdata = if_rdata_o; if_last_err = if_err_o; end
            if (d_rsp_valid_o && d_rr) begin d_last_rdata = d_rdata_o; d_last_err = d_err_o; end
            if (rst) begin
                chk("rst_ram_we", 32'(ram_we_o), 0);
                chk("rst_if_ready", 32'(if_req_ready_o), 0);
                chk("rst_d_ready", 32'(d_req_ready_o), 0);
            end else begin
                e_ifr = !m_pend && if_v && (!d_v || m_last);
                e_dr  = !m_pend && d_v && !e_ifr;
                acc   = m_pend && m_age == 1;
                inr   = in_rng(m_addr);
                e_ifv = m_pend && m_age == 2 && !m_own;
                e_dv  = m_pend && m_age == 2 && m_own;
                chk("if_req_ready", 32'(if_req_ready_o), 32'(e_ifr));
                chk("d_req_ready", 32'(d_req_ready_o), 32'(e_dr));
                chk("ram_we", 32'(ram_we_o), 32'(acc && m_we && inr));
                chk("ram_re", 32'(ram_re_o), 32'(acc && !m_we && inr));
                chk("ram_addr", ram_addr_o, acc ? m_addr : 32'h0);
                chk("ram_data", ram_data_o, acc ? m_wdata : 32'h0);
                chk("ram_wstrb", 32'(ram_wstrb_o), acc ? 32'(m_wstrb) : 32'h0);
                chk("if_rsp_valid", 32'(if_rsp_valid_o), 32'(e_ifv));
                chk("d_rsp_valid", 32'(d_rsp_valid_o), 32'(e_dv));
                if (e_ifv) begin
                    chk("if_rdata", if_rdata_o, m_rdata);
                    chk("if_err", 32'(if_err_o), 32'(m_err));
                end
                if (e_dv) begin
                    chk("d_rdata", d_rdata_o, m_rdata);
                    chk("d_err", 32'(d_err_o), 32'(m_err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete directed request; returns after the response handshake edge.
    task automatic req(input bit isd, input logic [31:0] a, input bit we,
                       input logic [3:0] st, input logic [31:0] wd);
        int n = 0;
        if (isd) begin d_v = 1'b1; d_a = a; d_we = we; d_st = st; d_wd = wd; end
        else begin if_v = 1'b1; if_a = a; end
        #1;
        while (!(isd ? d_req_ready_o : if_req_ready_o)) begin
            if (++n > 20) begin fail_now("req_timeout"); if_v = 1'b0; d_v = 1'b0; return; end
            tick();
        end
        tick();
        if (isd) d_v = 1'b0; else if_v = 1'b0;
        n = 0;
        while (!(isd ? (d_rsp_valid_o && d_rr) : (if_rsp_valid_o && if_rr))) begin
            if (++n > 20) begin fail_now("rsp_timeout"); return; end
            tick();
        end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0, r0, s0, bad;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_if_rsp_valid", 32'(if_rsp_valid_o), 0);
        chk("reset_d_rsp_valid", 32'(d_rsp_valid_o), 0);
        chk("reset_if_rdata", if_rdata_o, 0);
        chk("reset_d_rdata", d_rdata_o, 0);
        chk("reset_errs", 32'({if_err_o, d_err_o}), 0);
        chk("reset_ram", 32'({ram_we_o, ram_re_o, ram_wstrb_o}) | ram_addr_o | ram_data_o, 0);
        tick();

        // Contention right after reset: fetch first, then strict alternation
        glog.delete();
        if_v = 1'b1; if_a = 32'h10; d_v = 1'b1; d_a = 32'h20; d_we = 1'b0;
        repeat (12) tick();
        if_v = 1'b0; d_v = 1'b0;
        repeat (4) tick();
        chk("cont_count", 32'(glog.size()), 32'd4);
        if (glog.size() >= 4) begin
            chk("cont_g0", 32'(glog[0]), 0);
            chk("cont_g1", 32'(glog[1]), 1);
            chk("cont_g2", 32'(glog[2]), 0);
            chk("cont_g3", 32'(glog[3]), 1);
        end

        req(1'b0, 32'h10, 1'b0, 4'h0, 32'h0);
        chk("fetch_rdata", if_last_rdata, 32'hDEADBEEF);
        chk("fetch_err", 32'(if_last_err), 0);

        w0 = we_cnt;
        req(1'b1, 32'h20, 1'b1, 4'b0101, 32'hAABBCCDD);
        chk("store_we_cycles", 32'(we_cnt - w0), 1);
        chk("store_rdata", d_last_rdata, 0);
        req(1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
        chk("load_merged", d_last_rdata, 32'h11BB33DD);

        // Backpressure on the data response with a fetch waiting behind it
        d_rr = 1'b0; d_v = 1'b1; d_a = 32'h24; d_we = 1'b0;
        #1;
        n = 0;
        while (!d_req_ready_o && n < 20) begin n++; tick(); end
        tick();
        d_v = 1'b0; if_v = 1'b1; if_a = 32'h10;
        n = 0;
        while (!d_rsp_valid_o && n < 20) begin n++; tick(); end
        if (!d_rsp_valid_o) fail_now("bp_rsp_timeout");
        repeat (5) tick();
        d_rr = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_rdata", d_last_rdata, init_word(9));
        chk("bp_fetch_ready", 32'(if_req_ready_o), 1);
        tick();
        if_v = 1'b0;
        repeat (4) tick();

        // Out of range: errors, zero data, no RAM strobes
        w0 = we_cnt; r0 = re_cnt;
        req(1'b1, 32'h1000, 1'b0, 4'h0, 32'h0);
        chk("oor_load_err", 32'(d_last_err), 1);
        chk("oor_load_rdata", d_last_rdata, 0);
        req(1'b1, 32'h2000, 1'b1, 4'hF, 32'h12345678);
        chk("oor_store_err", 32'(d_last_err), 1);
        chk("oor_no_strobes", 32'((we_cnt - w0) + (re_cnt - r0)), 0);
        chk("oor_ram_word0", ram[0], init_word(0));

        // Reset during the RAM cycle of a store
        d_v = 1'b1; d_a = 32'h30; d_we = 1'b1; d_st = 4'hF; d_wd = 32'h55555555;
        #1;
        n = 0;
        while (!d_req_ready_o && n < 20) begin n++; tick(); end
        tick();
        rst = 1'b1; d_v = 1'b0;
        @(negedge clk);
        chk("midrst_we", 32'(ram_we_o), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_outs", 32'({if_req_ready_o, d_req_ready_o, if_rsp_valid_o, d_rsp_valid_o,
                                 ram_we_o, ram_re_o, ram_wstrb_o, if_err_o, d_err_o})
                            | ram_addr_o | ram_data_o | if_rdata_o | d_rdata_o, 0);
        s0 = d_seen;
        repeat (6) tick();
        chk("midrst_no_rsp", 32'(d_seen - s0), 0);
        chk("midrst_ram", ram[12], 32'hCAFEF00D);

        // Random traffic
        repeat (3000) begin
            if_v  = 1'($urandom_range(0, 1));
            d_v   = 1'($urandom_range(0, 1));
            if_a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * WORDS - 1));
            d_a   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * WORDS - 1));
            d_we  = 1'($urandom_range(0, 1));
            d_st  = 4'($urandom);
            d_wd  = $urandom;
            if_rr = ($urandom_range(0, 3) != 0);
            d_rr  = ($urandom_range(0, 3) != 0);
            tick();
        end
        if_v = 1'b0; d_v = 1'b0; if_rr = 1'b1; d_rr = 1'b1;
        repeat (5) tick();
        bad = 0;
        for (int i = 0; i < WORDS; i++) if (ram[i] !== mm[i]) bad++;
        chk("mem_final", 32'(bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
